layer_sequencer: RTL and testbench

Time-multiplexes one single-neuron MAC unit across the M output neurons of a fully connected layer. For each neuron in turn it fetches that neuron's weight vector from weight memory, starts the MAC, waits for its ready, and writes the 8-bit result to the layer output buffer. It also tracks a running argmax, so the final layer directly yields the classified digit. It sits between the top-level network controller and the neuron/weight-memory pair.

---
 rtl/layer_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_layer_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_sequencer.sv
// layer_sequencer: time-multiplexes one single-neuron MAC across the M output
// neurons of a fully connected layer, writes each 8-bit result to the output
// buffer and keeps a running argmax (lowest index wins ties).
module layer_sequencer #(
  parameter int unsigned M       = 10,
  parameter int unsigned IW      = $clog2(M),
  parameter int unsigned TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          layer_start,
  output logic          busy,
  output logic          layer_done,
  output logic          err,
  output logic          w_rd_en,
  output logic [IW-1:0] w_addr,
  output logic          nrn_start,
  output logic          nrn_shift_en,
  input  logic          nrn_ready,
  input  logic [7:0]    nrn_out,
  output logic          o_wr_en,
  output logic [IW-1:0] o_addr,
  output logic [7:0]    o_data,
  output logic [IW-1:0] max_idx,
  output logic [7:0]    max_val
);

  localparam int unsigned CW       = $clog2(TIMEOUT + 1);
  localparam int unsigned DW       = 8;
  localparam logic [IW-1:0] LAST   = IW'(M - 1);
  localparam logic [CW-1:0] CNT_TO = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAITW,
    S_START,
    S_RUN,
    S_STORE,
    S_DONE
  } state_t;

  state_t state, state_n;

  // datapath registers and their next values
  logic [IW-1:0] idx, idx_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [DW-1:0] cap, cap_n;
  logic [IW-1:0] run_idx, run_idx_n;
  logic [DW-1:0] run_val, run_val_n;
  logic [IW-1:0] max_idx_n;
  logic [DW-1:0] max_val_n;
  logic          err_n;
  logic          upd;

  // registered strobes, computed from the state being entered
  logic busy_n, done_n, rd_n, start_n, wr_n;

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // next-state, datapath updates and strobe decode
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    cnt_n     = cnt;
    cap_n     = cap;
    run_idx_n = run_idx;
    run_val_n = run_val;
    max_idx_n = max_idx;
    max_val_n = max_val;
    err_n     = err;
    upd       = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (layer_start) begin
          state_n   = S_FETCH;
          idx_n     = '0;
          err_n     = 1'b0;
          run_idx_n = '0;
          run_val_n = '0;
        end
      end
      S_FETCH: begin
        state_n = S_WAITW;
      end
      S_WAITW: begin
        state_n = S_START;
      end
      S_START: begin
        cnt_n   = '0;
        state_n = S_RUN;
      end
      S_RUN: begin
        cnt_n = cnt + CW'(1);
        // ready may still be high from the previous neuron on the first RUN cycle
        if ((cnt != '0) && nrn_ready) begin
          cap_n   = nrn_out;
          state_n = S_STORE;
        end else if (cnt == CNT_TO) begin
          err_n   = 1'b1;
          state_n = S_DONE;
        end
      end
      S_STORE: begin
        upd = (idx == '0) || (cap > run_val);
        if (upd) begin
          run_idx_n = idx;
          run_val_n = cap;
        end
        if (idx == LAST) begin
          max_idx_n = upd ? idx : run_idx;
          max_val_n = upd ? cap : run_val;
          state_n   = S_DONE;
        end else begin
          idx_n   = idx + IW'(1);
          state_n = S_FETCH;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    busy_n  = (state_n != S_IDLE);
    done_n  = (state_n == S_DONE);
    rd_n    = (state_n == S_FETCH);
    start_n = (state_n == S_START);
    wr_n    = (state_n == S_STORE);
  end

  // datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx          <= '0;
      cnt          <= '0;
      cap          <= '0;
      run_idx      <= '0;
      run_val      <= '0;
      max_idx      <= '0;
      max_val      <= '0;
      err          <= 1'b0;
      busy         <= 1'b0;
      layer_done   <= 1'b0;
      w_rd_en      <= 1'b0;
      nrn_start    <= 1'b0;
      nrn_shift_en <= 1'b0;
      o_wr_en      <= 1'b0;
    end else begin
      idx          <= idx_n;
      cnt          <= cnt_n;
      cap          <= cap_n;
      run_idx      <= run_idx_n;
      run_val      <= run_val_n;
      max_idx      <= max_idx_n;
      max_val      <= max_val_n;
      err          <= err_n;
      busy         <= busy_n;
      layer_done   <= done_n;
      w_rd_en      <= rd_n;
      nrn_start    <= start_n;
      nrn_shift_en <= start_n;
      o_wr_en      <= wr_n;
    end
  end

  // both memories are addressed by the current neuron index
  assign w_addr = idx;
  assign o_addr = idx;
  assign o_data = cap;

  // memory strobes and neuron start never overlap
  a_strobes_onehot: assert property (@(posedge clk) disable iff (!rst)
    $onehot0({o_wr_en, w_rd_en, nrn_start}));

  // the index never runs past the last neuron
  a_idx_in_range: assert property (@(posedge clk) disable iff (!rst)
    (state == S_FETCH) |-> (idx <= LAST));

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: behavioural neuron/weight-memory model, output
// write monitor and an argmax/latency reference computed per run.
module tb_layer_sequencer;

  localparam int unsigned M       = 10;
  localparam int unsigned IW      = $clog2(M);
  localparam int unsigned TIMEOUT = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          layer_start = 1'b0;
  logic          busy, layer_done, err, w_rd_en, nrn_start, nrn_shift_en, o_wr_en;
  logic [IW-1:0] w_addr, o_addr, max_idx;
  logic [7:0]    o_data, max_val;
  logic          nrn_ready = 1'b0;
  logic [7:0]    nrn_out = 8'h00;

  layer_sequencer #(.M(M), .IW(IW), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .layer_start  (layer_start),
    .busy         (busy),
    .layer_done   (layer_done),
    .err          (err),
    .w_rd_en      (w_rd_en),
    .w_addr       (w_addr),
    .nrn_start    (nrn_start),
    .nrn_shift_en (nrn_shift_en),
    .nrn_ready    (nrn_ready),
    .nrn_out      (nrn_out),
    .o_wr_en      (o_wr_en),
    .o_addr       (o_addr),
    .o_data       (o_data),
    .max_idx      (max_idx),
    .max_val      (max_val)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // neuron + weight memory model: result per row, ready after 'delay' cycles
  logic [7:0] vals [M];
  int delay    = 12;   // 0: ready held high permanently
  int hang_idx = -1;   // row whose neuron never becomes ready
  int row      = 0;
  int cd       = -1;

  always @(negedge clk) begin
    if (!rst) begin
      nrn_ready = 1'b0;
      cd        = -1;
    end else begin
      if (w_rd_en) row = int'(w_addr);
      if (nrn_start) begin
        if (row == hang_idx) begin
          nrn_ready = 1'b0;
          cd        = -1;
        end else if (delay == 0) begin
          nrn_out   = vals[row];
          nrn_ready = 1'b1;
        end else begin
          nrn_ready = 1'b0;
          cd        = delay;
        end
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          nrn_out   = vals[row];
          nrn_ready = 1'b1;
        end
      end
    end
  end

  // output-buffer write monitor and strobe-overlap counter
  typedef struct packed {
    logic [IW-1:0] a;
    logic [7:0]    d;
  } wr_t;
  wr_t wq[$];
  int  strobe_bad = 0;

  always @(negedge clk) begin
    if (rst) begin
      if (o_wr_en) wq.push_back('{a: o_addr, d: o_data});
      if (int'(o_wr_en) + int'(w_rd_en) + int'(nrn_start) > 1) strobe_bad++;
      if (nrn_start != nrn_shift_en) strobe_bad++;
    end
  end

  // argmax persisting across runs (aborted runs leave it untouched)
  int model_idx = 0;
  int model_val = 0;

  task automatic run_layer(input int d, input int hang, input bit pulse);
    int  r, n, lat, t0, bi;
    bit  e_err, seen;
    r     = (d < 2) ? 2 : d;
    e_err = (hang >= 0);
    n     = e_err ? hang : int'(M);
    lat   = e_err ? hang * (4 + r) + 4 + int'(TIMEOUT) : int'(M) * (4 + r) + 1;
    if (!e_err) begin
      bi = 0;
      for (int i = 1; i < int'(M); i++) if (vals[i] > vals[bi]) bi = i;
      model_idx = bi;
      model_val = int'(vals[bi]);
    end
    delay      = d;
    hang_idx   = hang;
    wq.delete();
    strobe_bad = 0;

    @(negedge clk);
    layer_start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    layer_start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("err_cleared", 32'(err), 32'd0);

    seen = 1'b0;
    for (int k = 0; k < 4000 && !seen; k++) begin
      if (layer_done) begin
        seen = 1'b1;
      end else begin
        if (pulse) layer_start = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
    end
    layer_start = 1'b0;
    chk("done_seen", 32'(seen), 32'd1);
    if (seen) begin
      chk("latency", 32'(cyc - t0), 32'(lat));
      chk("err_at_done", 32'(err), 32'(e_err));
      chk("max_idx", 32'(max_idx), 32'(model_idx));
      chk("max_val", 32'(max_val), 32'(model_val));
      chk("write_count", 32'(wq.size()), 32'(n));
      for (int i = 0; i < n && i < wq.size(); i++) begin
        chk("wr_addr", 32'(wq[i].a), 32'(i));
        chk("wr_data", 32'(wq[i].d), 32'(vals[i]));
      end
      @(negedge clk);
      chk("done_one_cycle", 32'(layer_done), 32'd0);
      chk("busy_after_done", 32'(busy), 32'd0);
      chk("err_held", 32'(err), 32'(e_err));
      repeat (2) @(negedge clk);
      chk("no_restart", 32'(busy), 32'd0);
      chk("no_extra_writes", 32'(wq.size()), 32'(n));
      chk("strobe_overlap", 32'(strobe_bad), 32'd0);
    end
  endtask

  task automatic rand_vals(input bit narrow);
    for (int i = 0; i < int'(M); i++)
      vals[i] = narrow ? 8'($urandom_range(0, 5)) : 8'($urandom);
  endtask

  initial begin
    bit hit;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", 32'({busy, layer_done, err, w_rd_en, nrn_start, nrn_shift_en, o_wr_en}), 32'd0);
    chk("rst_data", 32'({w_addr, o_addr, o_data, max_idx, max_val}), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // reference vector with a tie at the maximum
    vals = '{8'd3, 8'd9, 8'd1, 8'd9, 8'd0, 8'd2, 8'd7, 8'd4, 8'd8, 8'd5};
    run_layer(12, -1, 1'b0);

    // all-zero and all-ones results
    for (int i = 0; i < int'(M); i++) vals[i] = 8'h00;
    run_layer(3, -1, 1'b0);
    for (int i = 0; i < int'(M); i++) vals[i] = 8'hFF;
    run_layer(5, -1, 1'b0);

    // ready held high throughout
    rand_vals(1'b0);
    run_layer(0, -1, 1'b0);

    // clean run, then neuron 4 times out leaving max untouched
    rand_vals(1'b1);
    run_layer(7, -1, 1'b0);
    rand_vals(1'b0);
    run_layer(6, 4, 1'b0);

    // layer_start hammered during a run; also clears the prior err
    rand_vals(1'b0);
    run_layer(4, -1, 1'b1);

    // reset while neuron 6 is running
    vals = '{8'd3, 8'd9, 8'd1, 8'd9, 8'd0, 8'd2, 8'd7, 8'd4, 8'd8, 8'd5};
    delay    = 12;
    hang_idx = -1;
    @(negedge clk);
    layer_start = 1'b1;
    @(negedge clk);
    layer_start = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 2000 && !hit; k++) begin
      @(negedge clk);
      if (nrn_start && w_addr == IW'(6)) hit = 1'b1;
    end
    chk("reach_neuron6", 32'(hit), 32'd1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrun_rst_ctrl", 32'({busy, layer_done, err, w_rd_en, nrn_start, nrn_shift_en, o_wr_en}), 32'd0);
    chk("midrun_rst_data", 32'({w_addr, o_addr, o_data, max_idx, max_val}), 32'd0);
    model_idx = 0;
    model_val = 0;
    wq.delete();
    repeat (2) @(negedge clk);
    chk("rst_no_writes", 32'(wq.size()), 32'd0);
    rst = 1'b1;
    run_layer(12, -1, 1'b0);

    // randomized runs
    for (int t = 0; t < 8; t++) begin
      int d, h;
      rand_vals(1'($urandom_range(0, 1)));
      d = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 20));
      h = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, M - 1)) : -1;
      run_layer(d, h, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
